// File: rtl/beacon_classifier.sv
// beacon_classifier: multi-channel IR beacon frequency classifier.
// Counts synchronised input edges per channel over a fixed gate window,
// bands each channel as quiet/friendly/criminal, combines the bands into a
// window result and filters it through an N-window confirmation stage.
module beacon_classifier #(
    parameter int N_CH    = 4,
    parameter int WINDOW  = 10_000_000,
    parameter int CNT_W   = 11,
    parameter int LO_TH   = 12,
    parameter int HI_TH   = 190,
    parameter int CONFIRM = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_CH-1:0]       pt_in,
    output logic [1:0]            class_out,
    output logic [1:0]            raw_class,
    output logic                  window_done,
    output logic                  class_changed,
    output logic [N_CH*CNT_W-1:0] ch_count,
    output logic [N_CH-1:0]       ch_band
);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_FRIEND = 2'b01,
        CLS_CRIM   = 2'b10
    } class_e;

    localparam int                TW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]     TERM    = TW'(WINDOW - 1);
    localparam logic [TW-1:0]     TMR_ONE = TW'(1);
    localparam logic [CNT_W-1:0]  LO_C    = CNT_W'(LO_TH);
    localparam logic [CNT_W-1:0]  HI_C    = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [3:0]        CONF_C  = 4'(CONFIRM);

    // Input conditioning
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] sync_prev;
    logic [N_CH-1:0] edge_q;

    // Window state
    logic [TW-1:0]                 timer;
    logic                          terminal;
    logic [N_CH-1:0][CNT_W-1:0]    cnt;
    logic [N_CH-1:0][CNT_W-1:0]    cnt_nxt;
    logic [N_CH-1:0]               band_f;
    logic [N_CH-1:0]               band_c;
    class_e                        result;

    // Confirmation filter
    class_e     cand;
    class_e     cand_nxt;
    logic [3:0] run;
    logic [3:0] run_nxt;

    // Registered outputs
    class_e                  class_q;
    class_e                  raw_q;
    logic                    done_q;
    logic                    chg_q;
    logic [N_CH*CNT_W-1:0]   ch_count_q;
    logic [N_CH-1:0]         ch_band_q;

    // Two-flop synchroniser, previous-value register and registered edge strobe (free-running)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            edge_q    <= '0;
        end else begin
            sync1     <= pt_in;
            sync2     <= sync1;
            sync_prev <= sync2;
            edge_q    <= sync2 ^ sync_prev;
        end
    end

    assign terminal = en && (timer == TERM);

    // Saturating next count per channel and its band classification
    always_comb begin
        cnt_nxt = cnt;
        band_f  = '0;
        band_c  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (edge_q[i] && (cnt[i] != '1)) begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
            band_f[i] = (cnt_nxt[i] >= LO_C) && (cnt_nxt[i] < HI_C);
            band_c[i] = (cnt_nxt[i] >= HI_C);
        end
    end

    // Window result: friendly wins over criminal
    always_comb begin
        result = CLS_NONE;
        if (|band_f) begin
            result = CLS_FRIEND;
        end else if (|band_c) begin
            result = CLS_CRIM;
        end
    end

    // Candidate/run update applied at window close
    always_comb begin
        cand_nxt = cand;
        run_nxt  = run;
        if (result == cand) begin
            if (run < CONF_C) begin
                run_nxt = run + 4'd1;
            end
        end else begin
            cand_nxt = result;
            run_nxt  = 4'd1;
        end
    end

    // Timer, counters, filter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            cnt        <= '0;
            cand       <= CLS_NONE;
            run        <= '0;
            class_q    <= CLS_NONE;
            raw_q      <= CLS_NONE;
            done_q     <= 1'b0;
            chg_q      <= 1'b0;
            ch_count_q <= '0;
            ch_band_q  <= '0;
        end else if (!en) begin
            timer  <= '0;
            cnt    <= '0;
            run    <= '0;
            done_q <= 1'b0;
            chg_q  <= 1'b0;
        end else if (terminal) begin
            timer      <= '0;
            cnt        <= '0;
            done_q     <= 1'b1;
            raw_q      <= result;
            ch_count_q <= cnt_nxt;
            ch_band_q  <= band_f;
            cand       <= cand_nxt;
            run        <= run_nxt;
            if ((run_nxt == CONF_C) && (cand_nxt != class_q)) begin
                class_q <= cand_nxt;
                chg_q   <= 1'b1;
            end else begin
                chg_q   <= 1'b0;
            end
        end else begin
            timer  <= timer + TMR_ONE;
            cnt    <= cnt_nxt;
            done_q <= 1'b0;
            chg_q  <= 1'b0;
        end
    end

    assign class_out     = class_q;
    assign raw_class     = raw_q;
    assign window_done   = done_q;
    assign class_changed = chg_q;
    assign ch_count      = ch_count_q;
    assign ch_band       = ch_band_q;

endmodule

// File: tb/tb_beacon_classifier.sv
// tb_beacon_classifier: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a window-level model.
module tb_beacon_classifier;

    localparam int N_CH    = 4;
    localparam int WINDOW  = 100;
    localparam int CNT_W   = 5;
    localparam int LO_TH   = 3;
    localparam int HI_TH   = 20;
    localparam int CONFIRM = 2;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic [N_CH-1:0]       pt_in = '0;
    logic [1:0]            class_out;
    logic [1:0]            raw_class;
    logic                  window_done;
    logic                  class_changed;
    logic [N_CH*CNT_W-1:0] ch_count;
    logic [N_CH-1:0]       ch_band;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beacon_classifier #(
        .N_CH(N_CH), .WINDOW(WINDOW), .CNT_W(CNT_W),
        .LO_TH(LO_TH), .HI_TH(HI_TH), .CONFIRM(CONFIRM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pt_in(pt_in),
        .class_out(class_out), .raw_class(raw_class),
        .window_done(window_done), .class_changed(class_changed),
        .ch_count(ch_count), .ch_band(ch_band)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each input toggle sampled at a clock edge is credited three edges
    // later; a window is WINDOW consecutive enabled cycles.
    int              m_cnt[N_CH];
    int              m_timer;
    bit [N_CH-1:0]   m_last;
    bit [N_CH-1:0]   m_dq[$];
    bit [N_CH-1:0]   m_tog;
    bit [N_CH-1:0]   m_cur;
    int              m_cand, m_run;
    int              e_cls, e_raw, e_done, e_chg, e_band;
    int              e_count[N_CH];

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0;
            e_count[c] = 0;
        end
        m_timer = 0;
        m_last = '0;
        m_dq.delete();
        repeat (3) m_dq.push_back('0);
        m_cand = 0; m_run = 0;
        e_cls = 0; e_raw = 0; e_done = 0; e_chg = 0; e_band = 0;
    endtask

    task automatic close_window();
        int any_f, any_c, res, c;
        any_f = 0; any_c = 0; e_band = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            c = (m_cnt[ch] > SAT) ? SAT : m_cnt[ch];
            e_count[ch] = c;
            if (c >= LO_TH && c < HI_TH) begin
                any_f = 1;
                e_band = e_band | (1 << ch);
            end else if (c >= HI_TH) begin
                any_c = 1;
            end
            m_cnt[ch] = 0;
        end
        res = any_f ? 1 : (any_c ? 2 : 0);
        e_raw = res;
        if (res == m_cand) m_run = (m_run + 1 > CONFIRM) ? CONFIRM : m_run + 1;
        else begin m_cand = res; m_run = 1; end
        if (m_run == CONFIRM && m_cand != e_cls) begin
            e_cls = m_cand;
            e_chg = 1;
        end
        e_done = 1;
        m_timer = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_tog = pt_in ^ m_last;
            m_last = pt_in;
            m_dq.push_back(m_tog);
            m_cur = m_dq.pop_front();
            e_done = 0;
            e_chg = 0;
            if (en) begin
                for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] += int'(m_cur[ch]);
                m_timer++;
                if (m_timer == WINDOW) close_window();
            end else begin
                for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
                m_timer = 0;
                m_run = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        logic [N_CH*CNT_W-1:0] ev;
        #1;
        ev = '0;
        for (int ch = 0; ch < N_CH; ch++) ev[ch*CNT_W +: CNT_W] = CNT_W'(e_count[ch]);
        chk("cmp_window_done", window_done, e_done);
        chk("cmp_class_changed", class_changed, e_chg);
        chk("cmp_raw_class", raw_class, e_raw);
        chk("cmp_class_out", class_out, e_cls);
        chk("cmp_ch_band", ch_band, e_band);
        chk("cmp_ch_count", ch_count, ev);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (!window_done && k < budget);
        checks++;
        if (!window_done) begin
            errors++;
            $display("FAIL %s no window_done within %0d cycles", name, k);
        end
    endtask

    task automatic count_to_done(input string name, input int exp);
        int k;
        k = 0;
        do begin
            @(posedge clk); #2;
            k++;
        end while (!window_done && k < exp + 20);
        chk(name, k, exp);
    endtask

    // Called just after a window_done: drives one window's toggles, then
    // checks the closing window's outputs against literal expectations.
    task automatic win(input int n0, input int n1, input int n2, input int n3,
                       input bit term, input int x_raw, input int x_cls,
                       input int x_chg, input int x_band, input string tag);
        int n[N_CH];
        int exp_c;
        n = '{n0, n1, n2, n3};
        for (int j = 0; j < WINDOW; j++) begin
            @(negedge clk);
            for (int ch = 0; ch < N_CH; ch++)
                if (j < n[ch]) pt_in[ch] = ~pt_in[ch];
            if (term && j == WINDOW - 4) pt_in[0] = ~pt_in[0];
        end
        wait_done(3, {tag, "_done"});
        chk({tag, "_raw"}, raw_class, x_raw);
        chk({tag, "_class"}, class_out, x_cls);
        chk({tag, "_changed"}, class_changed, x_chg);
        chk({tag, "_band"}, ch_band, x_band);
        for (int ch = 0; ch < N_CH; ch++) begin
            exp_c = n[ch] + ((term && ch == 0) ? 1 : 0);
            if (exp_c > SAT) exp_c = SAT;
            chk($sformatf("%s_count%0d", tag, ch), ch_count[ch*CNT_W +: CNT_W], exp_c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int prob[N_CH];
        int drop_at, drop_len, drop_mode;
        int ptab[4];
        ptab = '{0, 3, 12, 40};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_class_out", class_out, 0);
        chk("rst_raw_class", raw_class, 0);
        chk("rst_window_done", window_done, 0);
        chk("rst_class_changed", class_changed, 0);
        chk("rst_ch_count", ch_count, 0);
        chk("rst_ch_band", ch_band, 0);

        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        count_to_done("first_window_latency", WINDOW);
        chk("w0_raw", raw_class, 0);

        // Friendly on channel 0
        win(10, 0, 0, 0, 0, 1, 0, 0, 4'b0001, "f1");
        win(10, 0, 0, 0, 0, 1, 1, 1, 4'b0001, "f2");
        // Criminal on channel 2, then friendly priority
        win(0, 0, 25, 0, 0, 2, 1, 0, 4'b0000, "c1");
        win(0, 0, 25, 0, 0, 2, 2, 1, 4'b0000, "c2");
        win(0, 10, 25, 0, 0, 1, 2, 0, 4'b0010, "p1");
        win(0, 10, 25, 0, 0, 1, 1, 1, 4'b0010, "p2");
        win(0, 10, 25, 0, 0, 1, 1, 0, 4'b0010, "p3");
        // Band boundaries on channel 3
        win(0, 0, 0, 2, 0, 0, 1, 0, 4'b0000, "b2");
        win(0, 0, 0, 3, 0, 1, 1, 0, 4'b1000, "b3");
        win(0, 0, 0, 19, 0, 1, 1, 0, 4'b1000, "b19");
        win(0, 0, 0, 20, 0, 2, 1, 0, 4'b0000, "b20");
        // Saturation
        win(0, 0, 0, 40, 0, 2, 2, 1, 4'b0000, "sat");
        // Alternating friendly/none; terminal-cycle edge lifts 2 to 3
        win(10, 0, 0, 0, 0, 1, 2, 0, 4'b0001, "a1");
        win(0, 0, 0, 0, 0, 0, 2, 0, 4'b0000, "a2");
        win(2, 0, 0, 0, 1, 1, 2, 0, 4'b0001, "a3_term");
        win(0, 0, 0, 0, 0, 0, 2, 0, 4'b0000, "a4");

        // Reset mid-window
        repeat (40) begin
            @(negedge clk);
            pt_in[1] = ~pt_in[1];
        end
        @(negedge clk);
        rst_n = 1'b0;
        pt_in = '0;
        #1;
        chk("midrst_class_out", class_out, 0);
        chk("midrst_raw_class", raw_class, 0);
        chk("midrst_ch_count", ch_count, 0);
        chk("midrst_ch_band", ch_band, 0);
        pulses = 0;
        repeat (150) begin
            @(posedge clk); #2;
            pulses += int'(window_done);
        end
        chk("midrst_no_pulse", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_to_done("post_reset_latency", WINDOW);
        win(10, 0, 0, 0, 0, 1, 0, 0, 4'b0001, "pr1");

        // Enable low for 300 cycles
        @(negedge clk);
        en = 1'b0;
        pulses = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (j < 290) pt_in = N_CH'($urandom);
            @(posedge clk); #2;
            pulses += int'(window_done) + int'(class_changed);
        end
        chk("en_low_no_pulse", pulses, 0);
        chk("en_low_raw_held", raw_class, 1);
        chk("en_low_band_held", ch_band, 1);
        chk("en_low_count_held", ch_count[CNT_W-1:0], 10);
        @(negedge clk);
        en = 1'b1;
        count_to_done("en_rise_latency", WINDOW);

        // Randomized phase, checked by the every-cycle compare
        for (int w = 0; w < 30; w++) begin
            for (int ch = 0; ch < N_CH; ch++) prob[ch] = ptab[$urandom_range(3)];
            drop_mode = ($urandom_range(4) == 0);
            drop_at = $urandom_range(WINDOW - 1);
            drop_len = $urandom_range(5, 1);
            for (int j = 0; j < WINDOW; j++) begin
                @(negedge clk);
                for (int ch = 0; ch < N_CH; ch++)
                    if ($urandom_range(99) < prob[ch]) pt_in[ch] = ~pt_in[ch];
                en = !(drop_mode && j >= drop_at && j < drop_at + drop_len);
            end
        end
        @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beacon_classifier.md
# beacon_classifier

Parametrised multi-channel IR beacon frequency classifier. Successor to the fixed 4-channel, 100 ms gate-window detector inside the motor driver. Sits between the phototransistor Pmod inputs and the display/decision logic. Adds:
- per-channel synchronisation and saturating edge counters;
- configurable window and threshold bands with no gaps;
- an N-window confirmation filter, so `class_out` only changes after consistent readings.

## Interface
Parameters:
- `N_CH`, 4, number of phototransistor channels (1–16)
- `WINDOW`, 10_000_000, gate window length in clock cycles (≥ 8)
- `CNT_W`, 11, edge-counter width per channel
- `LO_TH`, 12, edge count at which a channel enters the friendly band
- `HI_TH`, 190, edge count at which a channel enters the criminal band (`LO_TH` < `HI_TH` ≤ 2^`CNT_W`−1)
- `CONFIRM`, 2, consecutive identical window results required to change `class_out` (1–15)

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `en`  in  1  enable; low freezes classification
- `pt_in`  in  `N_CH`  raw phototransistor inputs, asynchronous
- `class_out`  out  2  confirmed class: 00 none, 01 friendly, 10 criminal; 11 never driven
- `raw_class`  out  2  unfiltered result of the last completed window, same encoding
- `window_done`  out  1  one-cycle pulse; `raw_class`, `ch_count` and `ch_band` are updated that cycle
- `class_changed`  out  1  one-cycle pulse, coincident with `window_done`, when `class_out` changes value
- `ch_count`  out  `N_CH*CNT_W`  per-channel edge counts of the last window; channel i is at bits [i*CNT_W +: CNT_W]
- `ch_band`  out  `N_CH`  bit i set when channel i was in the friendly band last window

## Operation
- Input conditioning: each `pt_in` bit passes through a 2-FF synchroniser. A third register holds the previous synchronised value. An edge is detected when the synchronised value differs from the previous one; rising and falling edges both count.
- Edge counters: one counter per channel, `CNT_W` bits wide.
  - Increments on each detected edge.
  - Saturates at 2^`CNT_W`−1; it never wraps.
- Window timer: counts 0..`WINDOW`−1 while `en` is high.
  - The cycle with timer == `WINDOW`−1 is the terminal cycle.
  - An edge detected on the terminal cycle belongs to the closing window.
  - Counters restart at 0 on the cycle after the terminal cycle.
- Channel band, evaluated at window close (count c):
  - c < `LO_TH` → quiet
  - `LO_TH` ≤ c < `HI_TH` → friendly
  - c ≥ `HI_TH` → criminal
- Window result:
  - friendly if any channel is friendly;
  - otherwise criminal if any channel is criminal;
  - otherwise none.
  - Friendly takes priority over criminal.
- Confirmation filter: holds a candidate class and a run counter.
  - When the window result equals the candidate, run = min(run+1, `CONFIRM`). Otherwise candidate = result and run = 1.
  - When run reaches `CONFIRM` and candidate ≠ `class_out`, `class_out` takes the candidate and `class_changed` pulses.
  - With `CONFIRM`=1, `class_out` follows `raw_class` every window.
- `en` low:
  - timer, counters and run counter are cleared; the candidate is kept;
  - no `window_done` pulse;
  - `class_out`, `raw_class`, `ch_count` and `ch_band` hold their values.
  - When `en` rises, a full `WINDOW` begins on that cycle.
- Synchroniser and previous-value registers run regardless of `en`.

## Timing
- Reset (`rst_n` low, asynchronous) clears all state and holds every output at 0 (`class_out`=00, `raw_class`=00, pulses low, `ch_count`=0, `ch_band`=0). The candidate resets to none with run 0.
- The first window starts on the first enabled clock after `rst_n` deasserts.
- An edge on `pt_in` is counted 3 clocks after it is sampled by the first synchroniser flop.
- Outputs are registered. `window_done`, `class_changed`, `raw_class`, `ch_count`, `ch_band` and `class_out` all update on the clock edge following the terminal cycle. Latency from window close to output is 1 cycle.
- `window_done` period is exactly `WINDOW` cycles while `en` is high.
- `rst_n` asserted mid-window: the partial window is discarded and no pulse is emitted.
- `en` dropping on the terminal cycle: that window is discarded.

## Test plan
Use `WINDOW`=100, `LO_TH`=3, `HI_TH`=20, `CNT_W`=5, `CONFIRM`=2, `N_CH`=4 for all scenarios.
- Channel 0 toggles 10 times per window, other channels static, for 2 windows → `raw_class`=01 both windows; `class_out` goes 00→01 with `class_changed` on the 2nd `window_done`; `ch_count`[4:0]=10; `ch_band`=0001.
- Channel 2 gets 25 edges per window → `raw_class`=10 and `class_out`=10 after 2 windows. Then 3 windows with channel 1 at 10 edges and channel 2 at 25 edges → class becomes friendly (01) on the 2nd of those windows.
- Boundary counts: exactly 2, 3, 19 and 20 edges on channel 3 → band quiet, friendly, friendly, criminal respectively.
- Saturation: 40 edges in one window → `ch_count`=31 with no wrap; result criminal.
- Alternating friendly/none windows → `raw_class` alternates; `class_out` never changes and `class_changed` never pulses. An edge on the terminal cycle is counted in the closing window.
- Reset and enable: `rst_n` low mid-window → all outputs 0 and no `window_done`. With `en` low for 300 cycles → no pulses and outputs held. After `en` rises → first `window_done` exactly 100 cycles later.
